// File: rtl/bpsk_pkg.sv
// Shared types and helpers for the BPSK/QPSK packet assembler.
package bpsk_pkg;

  // Assembler states: hunting for the sync word, or collecting payload symbols.
  typedef enum logic [0:0] {
    StHunt,
    StCollect
  } state_e;

  // Default sync pattern, right-aligned.
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  // Width of a counter able to hold 0..packet_size inclusive.
  function automatic int unsigned count_width(input int unsigned packet_size);
    return $clog2(packet_size + 1);
  endfunction

endpackage

// File: rtl/sync_detector.sv
// Sync word hunter: shift register of the most recent symbols plus an equality compare.
module sync_detector
  import bpsk_pkg::*;
#(
  parameter int unsigned         SYMBOL_BITS = 1,
  parameter int unsigned         SYNC_LEN    = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(SYNC_WORD_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [SYMBOL_BITS-1:0] sym,
  output logic                   hit
);

  logic [SYNC_LEN-1:0] sreg_q, sreg_d;

  // Newest symbol enters at the LSBs; hit reflects the value this strobe would leave behind.
  always_comb begin
    sreg_d = {sreg_q[SYNC_LEN-SYMBOL_BITS-1:0], sym};
    hit    = shift && !clear && (sreg_d == SYNC_WORD);
  end

  // Shift register state; clear wins over a same-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (clear) begin
      sreg_q <= '0;
    end else if (shift) begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/packet_assembler.sv
// Assembles demodulated symbols into fixed-size packets behind a valid/ready output register.
module packet_assembler
  import bpsk_pkg::*;
#(
  parameter int unsigned         PACKET_SIZE = 32,
  parameter int unsigned         SYMBOL_BITS = 1,
  parameter bit                  MSB_FIRST   = 1'b1,
  parameter bit                  SYNC_EN     = 1'b1,
  parameter int unsigned         SYNC_LEN    = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(SYNC_WORD_DEFAULT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 bit_valid,
  input  logic [SYMBOL_BITS-1:0]               bit_data,
  output logic [PACKET_SIZE-1:0]               pkt_data,
  output logic                                 pkt_valid,
  input  logic                                 pkt_ready,
  output logic                                 locked,
  output logic                                 overflow,
  output logic [count_width(PACKET_SIZE)-1:0] bit_count
);

  localparam int unsigned CountW     = count_width(PACKET_SIZE);
  localparam state_e      ResetState = SYNC_EN ? StHunt : StCollect;
  localparam logic [PACKET_SIZE-1:0] SymMask =
      {{(PACKET_SIZE - SYMBOL_BITS){1'b0}}, {SYMBOL_BITS{1'b1}}};

  state_e                 state_q, state_d;
  logic [CountW-1:0]      count_q, count_d;
  logic [PACKET_SIZE-1:0] asm_q, asm_d;
  logic [PACKET_SIZE-1:0] out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic        strobe, hunt_stb, collect_stb, complete, out_free, sync_hit;
  int unsigned base;

  // clear discards any strobe in the same cycle.
  assign strobe      = bit_valid && !clear;
  assign hunt_stb    = bit_valid && (state_q == StHunt);
  assign collect_stb = strobe && (state_q == StCollect);
  assign complete    = collect_stb && (count_q == CountW'(PACKET_SIZE - SYMBOL_BITS));
  // Output slot is free if empty or being drained this very cycle (no bubble at full rate).
  assign out_free    = !valid_q || pkt_ready;

  if (SYNC_EN) begin : g_sync
    sync_detector #(
      .SYMBOL_BITS (SYMBOL_BITS),
      .SYNC_LEN    (SYNC_LEN),
      .SYNC_WORD   (SYNC_WORD)
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .shift (hunt_stb),
      .sym   (bit_data),
      .hit   (sync_hit)
    );
  end else begin : g_nosync
    assign sync_hit = 1'b0;
  end

  // Place the incoming symbol at offset bit_count from the chosen end of the packet.
  always_comb begin
    asm_d = asm_q;
    if (MSB_FIRST) begin
      base = PACKET_SIZE - SYMBOL_BITS - 32'(count_q);
    end else begin
      base = 32'(count_q);
    end
    if (collect_stb) begin
      asm_d = (asm_q & ~(SymMask << base)) | (PACKET_SIZE'(bit_data) << base);
    end
  end

  // Next-state: FSM, symbol counter, output register handshake and sticky overflow.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (valid_q && pkt_ready) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (out_free) begin
        out_d   = asm_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (clear) begin
      state_d = ResetState;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == StHunt) begin
      if (sync_hit) begin
        state_d = StCollect;
      end
    end else if (collect_stb) begin
      if (complete) begin
        count_d = '0;
        state_d = ResetState;
      end else begin
        count_d = count_q + CountW'(SYMBOL_BITS);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ResetState;
      count_q <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pkt_data  = out_q;
  assign pkt_valid = valid_q;
  assign locked    = (state_q == StCollect);
  assign overflow  = ovf_q;
  assign bit_count = count_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Self-checking bench for packet_assembler: vector table, corner sequences, random vs model.
module tb_packet_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT A (MSB first) and DUT B (LSB first) share one stimulus stream.
  logic        clear_ab = 1'b0, valid_ab = 1'b0, ready_ab = 1'b1;
  logic [0:0]  data_ab = '0;
  logic [15:0] pkt_a, pkt_b;
  logic        pv_a, pv_b, lk_a, lk_b, ov_a, ov_b;
  logic [4:0]  cnt_a, cnt_b;

  // DUT C: QPSK, no sync, 32-bit packets.
  logic        clear_c = 1'b0, valid_c = 1'b0, ready_c = 1'b1;
  logic [1:0]  data_c = '0;
  logic [31:0] pkt_c;
  logic        pv_c, lk_c, ov_c;
  logic [5:0]  cnt_c;

  int errors = 0;
  int checks = 0;

  // Random-phase controls and reference model state.
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;
  int          low_run = 0;
  logic [7:0]  m_hist;
  bit          m_lock;
  logic [15:0] m_acc;
  int          m_n;
  int          m_total;
  int          got;
  logic [15:0] expq[$];
  logic [15:0] mon_e;

  typedef struct {
    logic [15:0] payload;
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  packet_assembler #(
    .PACKET_SIZE (16), .SYMBOL_BITS (1), .MSB_FIRST (1'b1), .SYNC_EN (1'b1),
    .SYNC_LEN (8), .SYNC_WORD (8'hA5)
  ) dut_a (
    .clk (clk), .rst (rst), .clear (clear_ab), .bit_valid (valid_ab), .bit_data (data_ab),
    .pkt_data (pkt_a), .pkt_valid (pv_a), .pkt_ready (ready_ab), .locked (lk_a),
    .overflow (ov_a), .bit_count (cnt_a)
  );

  packet_assembler #(
    .PACKET_SIZE (16), .SYMBOL_BITS (1), .MSB_FIRST (1'b0), .SYNC_EN (1'b1),
    .SYNC_LEN (8), .SYNC_WORD (8'hA5)
  ) dut_b (
    .clk (clk), .rst (rst), .clear (clear_ab), .bit_valid (valid_ab), .bit_data (data_ab),
    .pkt_data (pkt_b), .pkt_valid (pv_b), .pkt_ready (ready_ab), .locked (lk_b),
    .overflow (ov_b), .bit_count (cnt_b)
  );

  packet_assembler #(
    .PACKET_SIZE (32), .SYMBOL_BITS (2), .MSB_FIRST (1'b1), .SYNC_EN (1'b0),
    .SYNC_LEN (8), .SYNC_WORD (8'hA5)
  ) dut_c (
    .clk (clk), .rst (rst), .clear (clear_c), .bit_valid (valid_c), .bit_data (data_c),
    .pkt_data (pkt_c), .pkt_valid (pv_c), .pkt_ready (ready_c), .locked (lk_c),
    .overflow (ov_c), .bit_count (cnt_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  // Reference model: bit-level sync hunt, then 16 payload bits packed MSB first.
  task automatic model_bit(input logic b);
    if (!m_lock) begin
      m_hist = {m_hist[6:0], b};
      if (m_hist == 8'hA5) m_lock = 1'b1;
    end else begin
      m_acc = {m_acc[14:0], b};
      m_n++;
      if (m_n == 16) begin
        expq.push_back(m_acc);
        m_total++;
        m_n    = 0;
        m_lock = 1'b0;
      end
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) begin
      if (low_run >= 2) begin
        ready_ab = 1'b1;
        low_run  = 0;
      end else begin
        ready_ab = ($urandom_range(0, 3) != 0);
        low_run  = ready_ab ? 0 : low_run + 1;
      end
    end
  endtask

  task automatic send_ab(input logic b);
    valid_ab = 1'b1;
    data_ab  = b;
    if (mon_en) model_bit(b);
    tick();
    valid_ab = 1'b0;
    if (mon_en) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_bits_ab(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_ab(w[i]);
  endtask

  task automatic send_c(input logic [1:0] s);
    valid_c = 1'b1;
    data_c  = s;
    tick();
    valid_c = 1'b0;
  endtask

  // Random-phase scoreboard: every transfer on A must match the model, B its bit reversal.
  always @(negedge clk) begin
    if (mon_en && pv_a && ready_ab) begin
      got++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_extra: got packet %h, expected none", pkt_a);
      end else begin
        mon_e = expq.pop_front();
        check("rnd_msb", {16'h0, pkt_a}, {16'h0, mon_e});
        check("rnd_lsb", {16'h0, pkt_b}, {16'h0, rev16(mon_e)});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1, w2, wsel;
    int k;

    vecs[0] = '{16'hBEEF, 16'hBEEF, 16'hF77D};
    vecs[1] = '{16'h1234, 16'h1234, 16'h2C48};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{16'h8001, 16'h8001, 16'h8001};
    vecs[5] = '{16'h0F00, 16'h0F00, 16'h00F0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", {31'h0, pv_a}, 32'h0);
    check("rst_data_a", {16'h0, pkt_a}, 32'h0);
    check("rst_count_a", {27'h0, cnt_a}, 32'h0);
    check("rst_locked_a", {31'h0, lk_a}, 32'h0);
    check("rst_ovf_a", {31'h0, ov_a}, 32'h0);
    check("rst_locked_c", {31'h0, lk_c}, 32'h1);
    rst = 1'b0;
    tick();

    // QPSK, no sync: two packets on consecutive-cycle strobes.
    w1 = 32'h12345678;
    w2 = 32'h9ABCDEF0;
    for (int i = 0; i < 32; i++) begin
      wsel = (i < 16) ? w1 : w2;
      k    = i % 16;
      send_c(wsel[31 - 2 * k -: 2]);
      if (i < 31) begin
        valid_c = 1'b1;
      end
      if (i == 7) check("c_count_mid", {26'h0, cnt_c}, 32'd16);
      if (i == 14) check("c_valid_early", {31'h0, pv_c}, 32'h0);
      if (i == 15) begin
        check("c_valid_1", {31'h0, pv_c}, 32'h1);
        check("c_data_1", pkt_c, w1);
        check("c_count_wrap", {26'h0, cnt_c}, 32'h0);
      end
      if (i == 16) check("c_valid_drop", {31'h0, pv_c}, 32'h0);
      if (i == 31) begin
        check("c_valid_2", {31'h0, pv_c}, 32'h1);
        check("c_data_2", pkt_c, w2);
      end
    end
    valid_c = 1'b0;
    tick();

    // Output full, drained in the same cycle the next packet completes: loads, no overflow.
    ready_c = 1'b0;
    for (int i = 0; i < 16; i++) send_c(w1[31 - 2 * i -: 2]);
    check("c_hold_valid", {31'h0, pv_c}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) ready_c = 1'b1;
      send_c(w2[31 - 2 * i -: 2]);
    end
    check("c_swap_valid", {31'h0, pv_c}, 32'h1);
    check("c_swap_data", pkt_c, w2);
    check("c_swap_ovf", {31'h0, ov_c}, 32'h0);
    tick();
    check("c_swap_drain", {31'h0, pv_c}, 32'h0);

    // Vector table: sync then payload, ready held high.
    for (int v = 0; v < 6; v++) begin
      send_bits_ab(16'h00A5, 8);
      check("tbl_locked", {31'h0, lk_a}, 32'h1);
      send_bits_ab(vecs[v].payload >> 1, 15);
      check("tbl_valid_early", {31'h0, pv_a}, 32'h0);
      send_ab(vecs[v].payload[0]);
      check("tbl_valid", {31'h0, pv_a}, 32'h1);
      check("tbl_msb", {16'h0, pkt_a}, {16'h0, vecs[v].exp_msb});
      check("tbl_lsb", {16'h0, pkt_b}, {16'h0, vecs[v].exp_lsb});
      check("tbl_unlock", {31'h0, lk_a}, 32'h0);
      tick();
      check("tbl_valid_1cyc", {31'h0, pv_a}, 32'h0);
    end

    // Overflow: output stalled, second packet dropped; clear keeps the held packet.
    ready_ab = 1'b0;
    send_bits_ab(16'h00A5, 8);
    send_bits_ab(16'h1234, 16);
    send_bits_ab(16'h00A5, 8);
    send_bits_ab(16'h5678, 16);
    check("ovf_flag", {31'h0, ov_a}, 32'h1);
    check("ovf_keep_a", {16'h0, pkt_a}, 32'h1234);
    check("ovf_keep_b", {16'h0, pkt_b}, {16'h0, rev16(16'h1234)});
    clear_ab = 1'b1;
    tick();
    clear_ab = 1'b0;
    check("clr_ovf", {31'h0, ov_a}, 32'h0);
    check("clr_valid_kept", {31'h0, pv_a}, 32'h1);
    check("clr_data_kept", {16'h0, pkt_a}, 32'h1234);
    ready_ab = 1'b1;
    tick();
    check("clr_drain", {31'h0, pv_a}, 32'h0);

    // clear together with a strobe mid-packet.
    send_bits_ab(16'h00A5, 8);
    send_bits_ab(16'h0059, 7);
    check("mid_count", {27'h0, cnt_a}, 32'd7);
    check("mid_locked", {31'h0, lk_a}, 32'h1);
    clear_ab = 1'b1;
    valid_ab = 1'b1;
    data_ab  = 1'b1;
    tick();
    clear_ab = 1'b0;
    valid_ab = 1'b0;
    check("mclr_count", {27'h0, cnt_a}, 32'h0);
    check("mclr_hunt", {31'h0, lk_a}, 32'h0);
    send_bits_ab(16'h00A5, 8);
    send_bits_ab(16'hC3A7, 16);
    check("mclr_valid", {31'h0, pv_a}, 32'h1);
    check("mclr_data_a", {16'h0, pkt_a}, 32'hC3A7);
    check("mclr_data_b", {16'h0, pkt_b}, {16'h0, rev16(16'hC3A7)});
    tick();

    // Asynchronous reset mid-collect with a packet waiting.
    ready_ab = 1'b0;
    send_bits_ab(16'h00A5, 8);
    send_bits_ab(16'h1357, 16);
    send_bits_ab(16'h00A5, 8);
    send_bits_ab(16'h0015, 5);
    check("ar_pre_valid", {31'h0, pv_a}, 32'h1);
    check("ar_pre_count", {27'h0, cnt_a}, 32'd5);
    rst = 1'b1;
    #2;
    check("ar_valid", {31'h0, pv_a}, 32'h0);
    check("ar_data", {16'h0, pkt_a}, 32'h0);
    check("ar_count", {27'h0, cnt_a}, 32'h0);
    check("ar_locked", {31'h0, lk_a}, 32'h0);
    check("ar_valid_b", {31'h0, pv_b}, 32'h0);
    #3;
    rst      = 1'b0;
    ready_ab = 1'b1;
    tick();

    // Randomized stream against the reference model.
    m_hist     = 8'h00;
    m_lock     = 1'b0;
    m_acc      = 16'h0;
    m_n        = 0;
    m_total    = 0;
    got        = 0;
    mon_en     = 1'b1;
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      send_bits_ab(16'($urandom), $urandom_range(0, 4));
      send_bits_ab(16'h00A5, 8);
      send_bits_ab(16'($urandom), 16);
    end
    rand_ready = 1'b0;
    ready_ab   = 1'b1;
    repeat (4) tick();
    mon_en = 1'b0;
    check("rnd_count", got, m_total);
    check("rnd_left", expq.size(), 32'h0);
    check("rnd_ovf", {31'h0, ov_a}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
